ps2_keyboard_rx: RTL



---
 rtl/ps2_keyboard_rx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes device-to-host frames and folds E0/F0 prefixes into flags.
// Optional macro PS2_PARITY_EN enforces odd parity; without it the parity bit is ignored.
module ps2_keyboard_rx #(
    parameter int unsigned TIMEOUT = 25000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kdata,
    output logic       kext,
    output logic       krel,
    output logic       kdone,
    output logic       kerr
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       CODE_EXT = 8'hE0;
    localparam logic [7:0]       CODE_REL = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_d;
    logic             r_dat_s1;
    logic             r_dat_s2;
    logic             w_fall;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ext;
    logic             w_ext_nxt;
    logic             r_rel;
    logic             w_rel_nxt;
    logic [7:0]       w_kdata_nxt;
    logic             w_kext_nxt;
    logic             w_krel_nxt;
    logic             w_kdone_nxt;
    logic             w_kerr_nxt;
    logic             w_par_ok;

    // Two-flop synchronisers plus edge-detect flop; all preset high so reset cannot fake a fall.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_d & ~r_clk_s2;

`ifdef PS2_PARITY_EN
    logic r_par;
    logic w_par_nxt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_nxt;
        end
    end

    assign w_par_ok = ^{r_shift, r_par};
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
            kdata     <= '0;
            kext      <= 1'b0;
            krel      <= 1'b0;
            kdone     <= 1'b0;
            kerr      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ext     <= w_ext_nxt;
            r_rel     <= w_rel_nxt;
            kdata     <= w_kdata_nxt;
            kext      <= w_kext_nxt;
            krel      <= w_krel_nxt;
            kdone     <= w_kdone_nxt;
            kerr      <= w_kerr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = '0;
        w_ext_nxt   = r_ext;
        w_rel_nxt   = r_rel;
        w_kdata_nxt = kdata;
        w_kext_nxt  = kext;
        w_krel_nxt  = krel;
        w_kdone_nxt = 1'b0;
        w_kerr_nxt  = 1'b0;
`ifdef PS2_PARITY_EN
        w_par_nxt   = r_par;
`endif

        // Inactivity timeout inside a frame; a coincident fall takes priority.
        if ((r_state != S_IDLE) && !w_fall) begin
            if (r_cnt == TO_LAST) begin
                w_state_nxt = S_IDLE;
                w_kerr_nxt  = 1'b1;
                w_ext_nxt   = 1'b0;
                w_rel_nxt   = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_fall && !r_dat_s2) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    w_shift_nxt = {r_dat_s2, r_shift[7:1]};
                    w_bit_nxt   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_fall) begin
`ifdef PS2_PARITY_EN
                    w_par_nxt   = r_dat_s2;
`endif
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    if (r_dat_s2 && w_par_ok) begin
                        if (r_shift == CODE_EXT) begin
                            w_ext_nxt = 1'b1;
                        end else if (r_shift == CODE_REL) begin
                            w_rel_nxt = 1'b1;
                        end else begin
                            w_kdata_nxt = r_shift;
                            w_kext_nxt  = r_ext;
                            w_krel_nxt  = r_rel;
                            w_kdone_nxt = 1'b1;
                            w_ext_nxt   = 1'b0;
                            w_rel_nxt   = 1'b0;
                        end
                    end else begin
                        w_kerr_nxt = 1'b1;
                        w_ext_nxt  = 1'b0;
                        w_rel_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
